unsign_acc_framer: RTL
======================

# unsign_acc_framer

Framing controller that drives the input side of the unsigned scalar accumulator. It forwards a raw sample stream and generates the `acc_done` markers that delimit integrations of a programmable length. It is armed and stopped by control logic, and can be aligned to an external sync pulse. It sits directly upstream of the accumulator: its `dout`, `dout_valid` and `acc_done` connect to the accumulator's `din`, `din_valid` and `acc_done`.

## Interface
Parameters:
- `DIN_WIDTH`, 16: sample width, passed through unchanged.
- `LEN_WIDTH`, 16: width of the integration-length input and the internal sample counter.
- `FRAME_WIDTH`, 32: width of the emitted-frame counter.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  DIN_WIDTH  input sample.
- `din_valid`  in  1  sample qualifier.
- `arm`  in  1  single-cycle start request.
- `stop`  in  1  single-cycle stop request.
- `sync_en`  in  1  when 1, a start waits for `sync_in`.
- `sync_in`  in  1  external alignment pulse.
- `acc_len`  in  LEN_WIDTH  samples per integration; latched at each frame start.
- `dout`  out  DIN_WIDTH  registered sample to the accumulator.
- `dout_valid`  out  1  registered qualifier.
- `acc_done`  out  1  asserted with the first sample of each new integration.
- `frame_cnt`  out  FRAME_WIDTH  number of `acc_done` markers emitted since the last arm.
- `busy`  out  1  high when the state is not IDLE.
- `cfg_err`  out  1  sticky flag; `acc_len==0` was latched. Cleared by `arm` or reset.

## Operation
- States:
  - **IDLE**: `dout_valid` and `acc_done` are forced to 0.
  - **WAIT_SYNC**: waiting for alignment.
  - **RUN**: forwarding samples and generating frames.
  - **FLUSH**: emitting the closing marker.
- Transitions:
  - IDLE + `arm` → WAIT_SYNC if `sync_en`, else RUN. `arm` clears `frame_cnt` and `cfg_err` and sets `first`.
  - WAIT_SYNC + `sync_in` sets `sync_pend`. The first `din_valid` sample in the same or a later cycle starts frame 1 → RUN.
  - RUN + `stop` → FLUSH.
  - FLUSH: the next `din_valid` sample is forwarded with `acc_done=1`, then → IDLE.
  - `stop` in WAIT_SYNC → IDLE immediately; nothing is emitted.
- Frame start:
  - Applies to the first valid sample in RUN after arming, or any valid sample when `cnt==len_q`.
  - That sample is forwarded with `acc_done=1`.
  - `len_q <= acc_len` (0 is treated as 1 and sets `cfg_err`).
  - `cnt <= 1`; `frame_cnt` increments.
- Other valid samples in RUN: forwarded with `acc_done=0`; `cnt` increments.
- Meaning of markers: marker k (i.e. `frame_cnt==k`) makes the accumulator output integration k-1. Marker 1 flushes pre-arm content and is junk for the consumer.
- The FLUSH marker closes the last integration. It increments `frame_cnt` but does not reload `len_q`.
- Invalid cycles: forwarded with `dout_valid=0`, `acc_done=0`, and `dout` holding its last value. Counters hold.
- Simultaneous events:
  - `arm` and `stop` together in IDLE: `stop` wins, state stays IDLE.
  - `arm` outside IDLE is ignored.
  - `stop` in FLUSH is ignored.
  - A `sync_in` while in RUN is ignored.

## Timing
- All outputs are registered; latency is 1 cycle from `din`/`din_valid` to `dout`/`dout_valid`/`acc_done`.
- `frame_cnt` updates in the same cycle that `acc_done` is presented.
- Reset values: `dout=0`, `dout_valid=0`, `acc_done=0`, `frame_cnt=0`, `busy=0`, `cfg_err=0`. Internal state is IDLE, `cnt=0`, `len_q=1`, `sync_pend=0`.
- Reset asserted mid-frame: all outputs drop asynchronously to their reset values. No partial marker is emitted after release.
- `busy` rises the cycle after `arm` and falls the cycle after the FLUSH marker is emitted.
- A change to `acc_len` takes effect only at the next frame start. The period between markers is exactly `len_q` valid samples, regardless of invalid gaps.
- `cnt` and `len_q` are LEN_WIDTH unsigned, so the maximum integration is 2^LEN_WIDTH-1 samples.
- `frame_cnt` wraps modulo 2^FRAME_WIDTH without a flag.

## Structure
- Shared accumulator package holds:
  - the state encoding constants (IDLE, WAIT_SYNC, RUN, FLUSH; 2 bits);
  - the default widths shared with the accumulator (DIN_WIDTH, ACC_WIDTH, LEN_WIDTH).
- One natural sub-module, `frame_len_counter`: holds `len_q` and `cnt`, with load, increment and `last` outputs and the zero-length substitution.
- The top level holds the FSM, the output registers and `frame_cnt`.

## Test plan
- `acc_len=4`, `sync_en=0`, continuous valid, `arm`: `acc_done` appears on output samples 1, 5, 9, …; `frame_cnt` reads 1, 2, 3.
- `acc_len=3` with valid duty 50% (alternating): markers occur every 3 valid samples, i.e. every 6 cycles; `dout` holds during the gaps.
- `sync_en=1`, `arm` at cycle 10, `sync_in` at cycle 20, valid from cycle 0: no output valid before cycle 21; the first marker is at cycle 21.
- Change `acc_len` from 4 to 2 in the middle of frame 2: frame 2 still spans 4 samples; subsequent frames span 2.
- `stop` mid-frame with `acc_len=8`: the next valid sample carries `acc_done`; `busy` falls one cycle later; `dout_valid` then stays 0.
- `acc_len=0` at arm: `cfg_err=1` and a marker on every sample. `rst_n` pulse mid-run: all outputs read 0 immediately.

Source files
------------

// File: rtl/unsign_acc_framer_pkg.sv
// Shared definitions for the unsigned scalar accumulator and its input framer.
package unsign_acc_framer_pkg;

  // Default widths, shared with the downstream accumulator.
  localparam int DEFAULT_DIN_WIDTH   = 16;
  localparam int DEFAULT_ACC_WIDTH   = 48;
  localparam int DEFAULT_LEN_WIDTH   = 16;
  localparam int DEFAULT_FRAME_WIDTH = 32;

  // Framer control states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_RUN       = 2'd2,
    ST_FLUSH     = 2'd3
  } state_e;

endpackage

// File: rtl/unsign_acc_framer_if.sv
// Sample stream into the framer and the framed stream out to the accumulator.
interface unsign_acc_framer_if
  import unsign_acc_framer_pkg::*;
#(
  parameter int DIN_WIDTH = DEFAULT_DIN_WIDTH
) ();

  logic [DIN_WIDTH-1:0] din;
  logic                 din_valid;
  logic [DIN_WIDTH-1:0] dout;
  logic                 dout_valid;
  logic                 acc_done;

  // Source of raw samples, consumer of the framed stream.
  modport master (
    output din, din_valid,
    input  dout, dout_valid, acc_done
  );

  // The framer itself.
  modport slave (
    input  din, din_valid,
    output dout, dout_valid, acc_done
  );

endinterface

// File: rtl/unsign_acc_framer_frame_len_counter.sv
// Holds the latched integration length and the in-frame sample count.
// A zero length request is replaced by 1 so every sample becomes a frame.
module frame_len_counter #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 inc,
  input  logic [LEN_WIDTH-1:0] len_in,
  output logic                 last,
  output logic                 zero_len
);

  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt_q;

  assign zero_len = (len_in == '0);
  assign last     = (cnt_q == len_q);

  // Load restarts the count at the frame's first sample; inc counts the rest.
  // NOTE: clocked state is written with non-blocking assignments only, so every
  // register samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= LEN_WIDTH'(1);
      cnt_q <= '0;
    end else if (load) begin
      len_q <= zero_len ? LEN_WIDTH'(1) : len_in;
      cnt_q <= LEN_WIDTH'(1);
    end else if (inc) begin
      cnt_q <= cnt_q + LEN_WIDTH'(1);
    end
  end

endmodule

// File: rtl/unsign_acc_framer.sv
// Framing controller in front of the unsigned accumulator: forwards samples
// with one cycle of latency and marks the first sample of every integration.
module unsign_acc_framer
  import unsign_acc_framer_pkg::*;
#(
  parameter int DIN_WIDTH   = DEFAULT_DIN_WIDTH,
  parameter int LEN_WIDTH   = DEFAULT_LEN_WIDTH,
  parameter int FRAME_WIDTH = DEFAULT_FRAME_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  unsign_acc_framer_if.slave     bus,
  input  logic                   arm,
  input  logic                   stop,
  input  logic                   sync_en,
  input  logic                   sync_in,
  input  logic [LEN_WIDTH-1:0]   acc_len,
  output logic [FRAME_WIDTH-1:0] frame_cnt,
  output logic                   busy,
  output logic                   cfg_err
);

  state_e state_q, state_d;
  logic   first_q, first_d;
  logic   pend_q, pend_d;
  logic   busy_q, busy_d;
  logic   load, inc, emit, mark, clr;
  logic   last, zero_len;

  logic [DIN_WIDTH-1:0]   dout_q;
  logic                   dout_valid_q;
  logic                   acc_done_q;
  logic [FRAME_WIDTH-1:0] frame_cnt_q;
  logic                   cfg_err_q;

  frame_len_counter #(.LEN_WIDTH(LEN_WIDTH)) u_len_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .inc      (inc),
    .len_in   (acc_len),
    .last     (last),
    .zero_len (zero_len)
  );

  // Next-state and per-sample decisions: forward, mark, load or count.
  // NOTE: every variable gets a default before the case so that no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    pend_d  = pend_q;
    load    = 1'b0;
    inc     = 1'b0;
    emit    = 1'b0;
    mark    = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arm && !stop) begin
          state_d = sync_en ? ST_WAIT_SYNC : ST_RUN;
          first_d = 1'b1;
          pend_d  = 1'b0;
          clr     = 1'b1;
        end
      end
      ST_WAIT_SYNC: begin
        if (stop) begin
          state_d = ST_IDLE;
          pend_d  = 1'b0;
        end else if ((sync_in || pend_q) && bus.din_valid) begin
          emit    = 1'b1;
          mark    = 1'b1;
          load    = 1'b1;
          first_d = 1'b0;
          pend_d  = 1'b0;
          state_d = ST_RUN;
        end else if (sync_in) begin
          pend_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.din_valid) begin
          emit = 1'b1;
          if (first_q || last) begin
            mark    = 1'b1;
            load    = 1'b1;
            first_d = 1'b0;
          end else begin
            inc = 1'b1;
          end
        end
        if (stop) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Closing marker: ends the last integration without reloading len_q.
        if (bus.din_valid) begin
          emit    = 1'b1;
          mark    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // busy stays up while the closing marker is on the output.
    busy_d = (state_d != ST_IDLE) || (state_q == ST_FLUSH);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
    end
  end

  // Output stream registers; dout holds its last sample across invalid cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      acc_done_q   <= 1'b0;
    end else begin
      if (emit) dout_q <= bus.din;
      dout_valid_q <= emit;
      acc_done_q   <= mark;
    end
  end

  // Frame counter and sticky zero-length flag, both cleared by arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
    end else if (clr) begin
      frame_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      if (mark)             frame_cnt_q <= frame_cnt_q + FRAME_WIDTH'(1);
      if (load && zero_len) cfg_err_q   <= 1'b1;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.acc_done   = acc_done_q;
  assign frame_cnt      = frame_cnt_q;
  assign busy           = busy_q;
  assign cfg_err        = cfg_err_q;

endmodule
